// File: rtl/branch_hazard_unit.sv
// Branch/jump resolution and load-use hazard detection for the 5-stage RV32I pipeline.
// Issues a registered one-cycle PC redirect with flush and keeps saturating perf counters.
module branch_hazard_unit #(
  parameter int CNT_W         = 32,
  parameter int RST_PC_UNUSED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_has_rs2,
  input  logic             id_without_rs,
  input  logic             ex_valid,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic [7:0]       ex_jump_type,
  input  logic [31:0]      ex_rs1_val,
  input  logic [31:0]      ex_rs2_val,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  output logic             stall,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             ex_kill,
  output logic             misalign,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [0:0] {IDLE = 1'b0, REDIRECT = 1'b1} state_t;

  localparam logic [31:0]      RESET_PC = 32'(RST_PC_UNUSED);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_next_s;
  logic [31:0]       target_r, target_next_s, target_s;
  logic              redirect_valid_r, misalign_r;
  logic [CNT_W-1:0]  stall_cnt_r, flush_cnt_r;
  logic              cond_s, taken_s, hz_s, stall_s;
  logic              eq_s, lt_s, ltu_s;

  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  // Branch condition and target computation for the EX instruction.
  always_comb begin
    eq_s   = (ex_rs1_val == ex_rs2_val);
    lt_s   = ($signed(ex_rs1_val) < $signed(ex_rs2_val));
    ltu_s  = (ex_rs1_val < ex_rs2_val);
    cond_s = 1'b0;
    case (ex_jump_type)
      8'h01:        cond_s = eq_s;
      8'h02:        cond_s = !eq_s;
      8'h04:        cond_s = !lt_s;
      8'h08:        cond_s = lt_s;
      8'h10:        cond_s = !ltu_s;
      8'h20:        cond_s = ltu_s;
      8'h40, 8'h80: cond_s = 1'b1;
      default:      cond_s = 1'b0;
    endcase
    taken_s = ex_valid & is_onehot8(ex_jump_type) & cond_s;
    if (ex_jump_type[7]) begin
      target_s = (ex_rs1_val + ex_imm) & 32'hFFFF_FFFE;
    end else begin
      target_s = ex_pc + ex_imm;
    end
  end

  // Load-use hazard; a pending redirect flushes ID anyway, so no stall then.
  always_comb begin
    hz_s = ex_valid & ex_memread & (ex_rd != 5'd0) & id_valid & !id_without_rs &
           ((id_rs1 == ex_rd) | (id_has_rs2 & (id_rs2 == ex_rd)));
    if (state_r == IDLE) begin
      stall_s = hz_s;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Next-state logic: the EX result during REDIRECT is wrong-path and ignored.
  always_comb begin
    state_next_s  = IDLE;
    target_next_s = target_r;
    case (state_r)
      IDLE: begin
        if (taken_s) begin
          state_next_s  = REDIRECT;
          target_next_s = target_s;
        end else begin
          state_next_s  = IDLE;
        end
      end
      REDIRECT: state_next_s = IDLE;
      default:  state_next_s = IDLE;
    endcase
  end

  // State, target and registered redirect outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      target_r         <= RESET_PC;
      redirect_valid_r <= 1'b0;
      misalign_r       <= 1'b0;
    end else begin
      state_r          <= state_next_s;
      target_r         <= target_next_s;
      redirect_valid_r <= (state_next_s == REDIRECT);
      misalign_r       <= (state_next_s == REDIRECT) & target_next_s[1];
    end
  end

  // Saturating perf counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (redirect_valid_r && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
    end
  end

  assign stall          = stall_s;
  assign redirect_valid = redirect_valid_r;
  assign flush          = redirect_valid_r;
  assign ex_kill        = redirect_valid_r;
  assign misalign       = misalign_r;
  assign redirect_pc    = target_r;
  assign stall_cnt      = stall_cnt_r;
  assign flush_cnt      = flush_cnt_r;

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Scoreboard bench for branch_hazard_unit: per-cycle stimulus and expected outputs are
// queued by each scenario task and popped/compared as the DUT produces each cycle's outputs.
module tb_branch_hazard_unit;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic        rst;
    logic        exv;
    logic [7:0]  jt;
    logic [31:0] a, b, pc, imm;
    logic        mr;
    logic [4:0]  rd;
    logic        idv;
    logic [4:0]  r1, r2;
    logic        h2, wo;
  } stim_t;

  typedef struct packed {
    logic        rv, fl, kl, mis, st;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst, id_valid, id_has_rs2, id_without_rs, ex_valid, ex_memread;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic [7:0]  ex_jump_type;
  logic [31:0] ex_rs1_val, ex_rs2_val, ex_pc, ex_imm;
  logic stall, redirect_valid, flush, ex_kill, misalign;
  logic [31:0] redirect_pc;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;
  stim_t stim_q[$];
  exp_t  exp_q[$];

  always #5 clk = ~clk;

  branch_hazard_unit #(.CNT_W(CNT_W), .RST_PC_UNUSED(0)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_has_rs2(id_has_rs2), .id_without_rs(id_without_rs),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .ex_jump_type(ex_jump_type), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_pc(ex_pc), .ex_imm(ex_imm),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .ex_kill(ex_kill), .misalign(misalign),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic stim_t nop();
    stim_t s = '0;
    return s;
  endfunction

  function automatic stim_t br(input logic [7:0] jt, input logic [31:0] a, b, pc, imm);
    stim_t s = '0;
    s.exv = 1'b1; s.jt = jt; s.a = a; s.b = b; s.pc = pc; s.imm = imm;
    return s;
  endfunction

  function automatic stim_t ld(input logic [4:0] rd, r1, r2, input logic h2, wo);
    stim_t s = '0;
    s.exv = 1'b1; s.mr = 1'b1; s.rd = rd; s.idv = 1'b1;
    s.r1 = r1; s.r2 = r2; s.h2 = h2; s.wo = wo;
    return s;
  endfunction

  // Expected observation: redirect flag drives redirect_valid, flush and ex_kill together.
  function automatic exp_t ex(input logic rv, input logic [31:0] pc, input logic mis, st);
    exp_t e;
    e.rv = rv; e.fl = rv; e.kl = rv; e.mis = mis; e.st = st; e.pc = pc;
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o = {redirect_valid, flush, ex_kill, misalign, stall, redirect_pc};
    return o;
  endfunction

  task automatic apply(input stim_t s);
    rst = s.rst; ex_valid = s.exv; ex_jump_type = s.jt;
    ex_rs1_val = s.a; ex_rs2_val = s.b; ex_pc = s.pc; ex_imm = s.imm;
    ex_memread = s.mr; ex_rd = s.rd; id_valid = s.idv;
    id_rs1 = s.r1; id_rs2 = s.r2; id_has_rs2 = s.h2; id_without_rs = s.wo;
  endtask

  task automatic do_reset();
    stim_t s = nop();
    s.rst = 1'b1;
    apply(s);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t e, o;
    int cyc = 0;
    do_reset();
    stim_q.push_back(nop()); exp_q.push_back(ex(1'b0, 32'h0, 1'b0, 1'b0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front()); #1;
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL reset cyc%0d got=%h exp=%h", cyc, o, e); end
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      failures++; $display("FAIL reset_cnt got=%h/%h exp=0/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_beq();
    exp_t e, o;
    int cyc = 0;
    do_reset();
    stim_q.push_back(br(8'h01, 32'd5, 32'd5, 32'h100, 32'h20)); exp_q.push_back(ex(1'b0, 32'h0, 1'b0, 1'b0));
    stim_q.push_back(nop()); exp_q.push_back(ex(1'b1, 32'h120, 1'b0, 1'b0));
    stim_q.push_back(nop()); exp_q.push_back(ex(1'b0, 32'h120, 1'b0, 1'b0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front()); #1;
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL beq cyc%0d got=%h exp=%h", cyc, o, e); end
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (flush_cnt !== 4'd1) begin failures++; $display("FAIL beq_flush_cnt got=%0d exp=1", flush_cnt); end
  endtask

  task automatic test_jump_targets();
    exp_t e, o;
    int cyc = 0;
    do_reset();
    stim_q.push_back(br(8'h80, 32'h2003, 32'h0, 32'h500, 32'h4)); exp_q.push_back(ex(1'b0, 32'h0, 1'b0, 1'b0));
    stim_q.push_back(nop()); exp_q.push_back(ex(1'b1, 32'h2006, 1'b1, 1'b0));
    stim_q.push_back(br(8'h40, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h8)); exp_q.push_back(ex(1'b0, 32'h2006, 1'b0, 1'b0));
    stim_q.push_back(nop()); exp_q.push_back(ex(1'b1, 32'h4, 1'b0, 1'b0));
    stim_q.push_back(nop()); exp_q.push_back(ex(1'b0, 32'h4, 1'b0, 1'b0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front()); #1;
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL jump cyc%0d got=%h exp=%h", cyc, o, e); end
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (flush_cnt !== 4'd2) begin failures++; $display("FAIL jump_flush_cnt got=%0d exp=2", flush_cnt); end
  endtask

  task automatic test_compare();
    exp_t e, o;
    int cyc = 0;
    logic [31:0] m1 = 32'hFFFF_FFFF;
    do_reset();
    stim_q.push_back(br(8'h08, m1, 32'd1, 32'h1000, 32'h40)); exp_q.push_back(ex(1'b0, 32'h0, 1'b0, 1'b0));
    stim_q.push_back(nop()); exp_q.push_back(ex(1'b1, 32'h1040, 1'b0, 1'b0));
    stim_q.push_back(br(8'h20, m1, 32'd1, 32'h2000, 32'h40)); exp_q.push_back(ex(1'b0, 32'h1040, 1'b0, 1'b0));
    stim_q.push_back(br(8'h04, m1, 32'd1, 32'h3000, 32'h40)); exp_q.push_back(ex(1'b0, 32'h1040, 1'b0, 1'b0));
    stim_q.push_back(br(8'h10, m1, 32'd1, 32'h4000, 32'h10)); exp_q.push_back(ex(1'b0, 32'h1040, 1'b0, 1'b0));
    stim_q.push_back(nop()); exp_q.push_back(ex(1'b1, 32'h4010, 1'b0, 1'b0));
    stim_q.push_back(br(8'h01, m1, 32'd1, 32'h5000, 32'h8)); exp_q.push_back(ex(1'b0, 32'h4010, 1'b0, 1'b0));
    stim_q.push_back(br(8'h03, 32'd7, 32'd7, 32'h6000, 32'h8)); exp_q.push_back(ex(1'b0, 32'h4010, 1'b0, 1'b0));
    stim_q.push_back(br(8'h00, 32'd7, 32'd7, 32'h7000, 32'h8)); exp_q.push_back(ex(1'b0, 32'h4010, 1'b0, 1'b0));
    stim_q.push_back(nop()); exp_q.push_back(ex(1'b0, 32'h4010, 1'b0, 1'b0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front()); #1;
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL compare cyc%0d got=%h exp=%h", cyc, o, e); end
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (flush_cnt !== 4'd2) begin failures++; $display("FAIL compare_flush_cnt got=%0d exp=2", flush_cnt); end
  endtask

  task automatic test_load_use();
    exp_t e, o;
    stim_t s;
    int cyc = 0;
    do_reset();
    stim_q.push_back(ld(5'd5, 5'd5, 5'd0, 1'b0, 1'b0)); exp_q.push_back(ex(1'b0, 32'h0, 1'b0, 1'b1));
    stim_q.push_back(nop()); exp_q.push_back(ex(1'b0, 32'h0, 1'b0, 1'b0));
    stim_q.push_back(ld(5'd0, 5'd0, 5'd0, 1'b1, 1'b0)); exp_q.push_back(ex(1'b0, 32'h0, 1'b0, 1'b0));
    stim_q.push_back(ld(5'd5, 5'd5, 5'd0, 1'b0, 1'b1)); exp_q.push_back(ex(1'b0, 32'h0, 1'b0, 1'b0));
    stim_q.push_back(ld(5'd5, 5'd3, 5'd5, 1'b0, 1'b0)); exp_q.push_back(ex(1'b0, 32'h0, 1'b0, 1'b0));
    stim_q.push_back(ld(5'd5, 5'd3, 5'd5, 1'b1, 1'b0)); exp_q.push_back(ex(1'b0, 32'h0, 1'b0, 1'b1));
    s = ld(5'd5, 5'd5, 5'd5, 1'b1, 1'b0); s.mr = 1'b0;
    stim_q.push_back(s); exp_q.push_back(ex(1'b0, 32'h0, 1'b0, 1'b0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front()); #1;
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL load_use cyc%0d got=%h exp=%h", cyc, o, e); end
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (stall_cnt !== 4'd2) begin failures++; $display("FAIL load_use_stall_cnt got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    exp_t e, o;
    stim_t s;
    int cyc = 0;
    do_reset();
    stim_q.push_back(br(8'h01, 32'd1, 32'd1, 32'h600, 32'h10)); exp_q.push_back(ex(1'b0, 32'h0, 1'b0, 1'b0));
    s = br(8'h02, 32'd1, 32'd2, 32'h700, 32'h100);
    s.mr = 1'b1; s.rd = 5'd5; s.idv = 1'b1; s.r1 = 5'd5;
    stim_q.push_back(s); exp_q.push_back(ex(1'b1, 32'h610, 1'b0, 1'b0));
    stim_q.push_back(nop()); exp_q.push_back(ex(1'b0, 32'h610, 1'b0, 1'b0));
    stim_q.push_back(nop()); exp_q.push_back(ex(1'b0, 32'h610, 1'b0, 1'b0));
    s = br(8'h40, 32'd0, 32'd0, 32'h800, 32'h24);
    s.mr = 1'b1; s.rd = 5'd5; s.idv = 1'b1; s.r1 = 5'd5;
    stim_q.push_back(s); exp_q.push_back(ex(1'b0, 32'h610, 1'b0, 1'b1));
    stim_q.push_back(nop()); exp_q.push_back(ex(1'b1, 32'h824, 1'b0, 1'b0));
    stim_q.push_back(nop()); exp_q.push_back(ex(1'b0, 32'h824, 1'b0, 1'b0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front()); #1;
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL back_to_back cyc%0d got=%h exp=%h", cyc, o, e); end
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (flush_cnt !== 4'd2 || stall_cnt !== 4'd1) begin
      failures++; $display("FAIL back_to_back_cnt got=%0d/%0d exp=2/1", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_reset_redirect_and_saturation();
    exp_t e, o;
    stim_t s;
    int cyc = 0;
    do_reset();
    stim_q.push_back(br(8'h01, 32'd5, 32'd5, 32'h100, 32'h20)); exp_q.push_back(ex(1'b0, 32'h0, 1'b0, 1'b0));
    s = nop(); s.rst = 1'b1;
    stim_q.push_back(s); exp_q.push_back(ex(1'b1, 32'h120, 1'b0, 1'b0));
    stim_q.push_back(nop()); exp_q.push_back(ex(1'b0, 32'h0, 1'b0, 1'b0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front()); #1;
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL reset_redirect cyc%0d got=%h exp=%h", cyc, o, e); end
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (flush_cnt !== 4'd0 || stall_cnt !== 4'd0) begin
      failures++; $display("FAIL reset_redirect_cnt got=%0d/%0d exp=0/0", flush_cnt, stall_cnt);
    end
    for (int k = 0; k < 17; k++) begin
      stim_q.push_back(ld(5'd7, 5'd7, 5'd0, 1'b0, 1'b0)); exp_q.push_back(ex(1'b0, 32'h0, 1'b0, 1'b1));
    end
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front()); #1;
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL saturate cyc%0d got=%h exp=%h", cyc, o, e); end
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (stall_cnt !== 4'hF) begin failures++; $display("FAIL stall_cnt_sat got=%0d exp=15", stall_cnt); end
  endtask

  initial begin
    apply(nop());
    test_reset();
    test_beq();
    test_jump_targets();
    test_compare();
    test_load_use();
    test_back_to_back();
    test_reset_redirect_and_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
